// File: rtl/cache_fill_arbiter_if.sv
// cache_fill_arbiter_if: request, memory and fill-return signals shared by the
// arbiter, both cache controllers and main memory. The master modport is the
// arbiter's view; the slave modport is the view of the surrounding system.
interface cache_fill_arbiter_if #(
    parameter int BLOCK_WORDS = 8
);
    localparam int WORD_W = $clog2(BLOCK_WORDS);

    logic              i_req;
    logic [15:0]       i_addr;
    logic              d_req;
    logic              d_wr;
    logic [15:0]       d_addr;
    logic [15:0]       d_wdata;
    logic              mem_en;
    logic              mem_wr;
    logic [15:0]       mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              mem_valid;
    logic [15:0]       fill_data;
    logic [WORD_W-1:0] fill_word;
    logic              i_fill_we;
    logic              d_fill_we;
    logic              i_done;
    logic              d_done;
    logic              busy;

    modport master (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
        output mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
               i_fill_we, d_fill_we, i_done, d_done, busy
    );

    modport slave (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
        input  mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
               i_fill_we, d_fill_we, i_done, d_done, busy
    );
endinterface

// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter: shares one fixed-latency memory between the I-cache fill
// path and the D-cache fill/write-through path. One request is served at a
// time: a block fill issues BLOCK_WORDS back-to-back reads and completes on the
// last counted return; a D write is a single one-cycle access.
// Optional feature: define ARB_RR_EN to alternate grants on simultaneous
// requests (D first after reset); undefined gives fixed D-over-I priority.
module cache_fill_arbiter #(
    parameter int BLOCK_WORDS = 8,
    parameter int MEM_LAT     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    cache_fill_arbiter_if.master   bus
);
    localparam int WORD_W = $clog2(BLOCK_WORDS);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FILL_I  = 2'd1;
    localparam logic [1:0] ST_FILL_D  = 2'd2;
    localparam logic [1:0] ST_WRITE_D = 2'd3;

    localparam logic [15:0]       BLOCK_SPAN = 16'(2 * BLOCK_WORDS);
    localparam logic [15:0]       BASE_MASK  = ~(BLOCK_SPAN - 16'd1);
    localparam logic [WORD_W:0]   ISSUE_END  = (WORD_W + 1)'(BLOCK_WORDS);
    localparam logic [WORD_W-1:0] LAST_WORD  = WORD_W'(BLOCK_WORDS - 1);

    // Reject configurations the counters and address masking cannot represent.
    if (BLOCK_WORDS < 2 || BLOCK_WORDS > 16 ||
        (BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0 || MEM_LAT < 1) begin : g_param_err
        $error("cache_fill_arbiter: BLOCK_WORDS must be a power of two in 2..16, MEM_LAT >= 1");
    end

    logic [1:0]        state_r;
    logic [15:0]       base_r;
    logic [15:0]       wdata_r;
    logic [WORD_W:0]   issue_cnt_r;
    logic [WORD_W-1:0] ret_cnt_r;
    logic              grant_d_s;
    logic              grant_i_s;
    logic              filling_s;
    logic              issue_s;
    logic              ret_s;
    logic              last_ret_s;

`ifdef ARB_RR_EN
    logic              last_grant_d_r;   // 1: D was granted last, 0: I (reset)

    // Remember which side won the most recent grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_d_r <= 1'b0;
        end else if (grant_d_s) begin
            last_grant_d_r <= 1'b1;
        end else if (grant_i_s) begin
            last_grant_d_r <= 1'b0;
        end else begin
            last_grant_d_r <= last_grant_d_r;
        end
    end

    // IDLE arbitration: alternate on a tie, a lone request always wins.
    always_comb begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (bus.d_req && bus.i_req) begin
                grant_d_s = ~last_grant_d_r;
                grant_i_s = last_grant_d_r;
            end else begin
                grant_d_s = bus.d_req;
                grant_i_s = bus.i_req;
            end
        end else begin
            grant_d_s = 1'b0;
            grant_i_s = 1'b0;
        end
    end
`else
    // IDLE arbitration: fixed priority, D over I.
    always_comb begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        if (state_r == ST_IDLE) begin
            grant_d_s = bus.d_req;
            grant_i_s = bus.i_req & ~bus.d_req;
        end else begin
            grant_d_s = 1'b0;
            grant_i_s = 1'b0;
        end
    end
`endif

    // Fill bookkeeping: returns only count while a fill owns the memory.
    always_comb begin
        filling_s  = (state_r == ST_FILL_I) || (state_r == ST_FILL_D);
        issue_s    = filling_s && (issue_cnt_r < ISSUE_END);
        ret_s      = filling_s && bus.mem_valid;
        last_ret_s = ret_s && (ret_cnt_r == LAST_WORD);
    end

    // State, latched block base / write data, issue and return counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            base_r      <= 16'h0000;
            wdata_r     <= 16'h0000;
            issue_cnt_r <= '0;
            ret_cnt_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    issue_cnt_r <= '0;
                    ret_cnt_r   <= '0;
                    if (grant_d_s) begin
                        state_r <= bus.d_wr ? ST_WRITE_D : ST_FILL_D;
                        base_r  <= bus.d_wr ? (bus.d_addr & 16'hFFFE) : (bus.d_addr & BASE_MASK);
                        wdata_r <= bus.d_wr ? bus.d_wdata : 16'h0000;
                    end else if (grant_i_s) begin
                        state_r <= ST_FILL_I;
                        base_r  <= bus.i_addr & BASE_MASK;
                        wdata_r <= 16'h0000;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FILL_I, ST_FILL_D: begin
                    if (issue_s) begin
                        issue_cnt_r <= issue_cnt_r + 1'b1;
                    end
                    if (ret_s) begin
                        ret_cnt_r <= ret_cnt_r + 1'b1;
                    end
                    if (last_ret_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WRITE_D: begin
                    state_r <= ST_IDLE;
                    wdata_r <= 16'h0000;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory issue, fill steering and completion pulses from the current state.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_addr  = 16'h0000;
        bus.mem_wdata = 16'h0000;
        if (issue_s) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = base_r | 16'({issue_cnt_r[WORD_W-1:0], 1'b0});
        end else if (state_r == ST_WRITE_D) begin
            bus.mem_en    = 1'b1;
            bus.mem_wr    = 1'b1;
            bus.mem_addr  = base_r;
            bus.mem_wdata = wdata_r;
        end else begin
            bus.mem_en = 1'b0;
        end
        bus.fill_data = bus.mem_rdata;
        bus.fill_word = ret_cnt_r;
        bus.i_fill_we = ret_s && (state_r == ST_FILL_I);
        bus.d_fill_we = ret_s && (state_r == ST_FILL_D);
        bus.i_done    = last_ret_s && (state_r == ST_FILL_I);
        bus.d_done    = (last_ret_s && (state_r == ST_FILL_D)) || (state_r == ST_WRITE_D);
        bus.busy      = (state_r != ST_IDLE);
    end
endmodule
